// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate pattern sequencer and its optional
// response checker (compiled in with GATE_PATTERN_SEQ_CHECK_EN).
package gate_seq_pkg;

    localparam int PATTERN_W    = 3;
    localparam int NUM_PATTERNS = 8;
    localparam int ERR_CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic is_last_pattern(input logic [PATTERN_W-1:0] pattern);
        return pattern == PATTERN_W'(NUM_PATTERNS - 1);
    endfunction

endpackage

// File: rtl/gate_seq_checker.sv
// Response checker: compares the downstream gate's OR/NOR outputs against the
// driven pattern on the last dwell cycle of each pattern; saturating error count.
module gate_seq_checker
    import gate_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 sample_i,
    input  logic [PATTERN_W-1:0] pattern_i,
    input  logic                 d_in,
    input  logic                 e_in,
    output logic                 mismatch,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic                 gate_or;
    logic                 diff;
    logic                 mismatch_q;
    logic                 mismatch_d;
    logic [ERR_CNT_W-1:0] err_q;
    logic [ERR_CNT_W-1:0] err_d;

    assign gate_or = |pattern_i;
    assign diff    = sample_i && ((d_in != gate_or) || (e_in != ~gate_or));

    always_comb begin
        mismatch_d = diff;
        err_d      = err_q;
        if (clear_i) begin
            err_d = '0;
        end else if (diff && (err_q != '1)) begin
            err_d = err_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign mismatch = mismatch_q;
    assign err_cnt  = err_q;

endmodule

// File: rtl/gate_pattern_seq.sv
// Sweeps {a,b,c} through 000..111, holding each pattern for a latched dwell count.
// Optional response checker compiled in with GATE_PATTERN_SEQ_CHECK_EN.
module gate_pattern_seq
    import gate_seq_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               valid,
    output logic               busy,
    output logic               done
`ifdef GATE_PATTERN_SEQ_CHECK_EN
    ,
    input  logic                 d_in,
    input  logic                 e_in,
    output logic                 mismatch,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    // start is a one-cycle request taken only in IDLE; busy covers DRIVE and
    // DONE, and any start seen while busy is dropped rather than queued.
    state_e               state_q, state_d;
    logic [PATTERN_W-1:0] pat_q, pat_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 accept;
    logic                 last_dwell;

    assign accept     = (state_q == IDLE) && start;
    assign last_dwell = (cnt_q == (dwell_q - DWELL_W'(1)));

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    pat_d   = '0;
                    cnt_d   = '0;
                    dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
                end
            end
            DRIVE: begin
                if (last_dwell) begin
                    cnt_d = '0;
                    if (is_last_pattern(pat_q)) begin
                        state_d = DONE;
                        pat_d   = '0;
                    end else begin
                        pat_d = pat_q + PATTERN_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= DWELL_W'(1);
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
        end
    end

    // Outputs decode straight from state so reset clears them without a clock.
    assign valid     = (state_q == DRIVE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign {a, b, c} = valid ? pat_q : '0;

`ifdef GATE_PATTERN_SEQ_CHECK_EN
    gate_seq_checker u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (accept),
        .sample_i  (valid && last_dwell),
        .pattern_i (pat_q),
        .d_in      (d_in),
        .e_in      (e_in),
        .mismatch  (mismatch),
        .err_cnt   (err_cnt)
    );
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_gate_pattern_seq.sv
// Randomized scoreboard bench for gate_pattern_seq; checker scenarios are
// added when GATE_PATTERN_SEQ_CHECK_EN is defined.
module tb_gate_pattern_seq;

    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic               a, b, c, valid, busy, done;
`ifdef GATE_PATTERN_SEQ_CHECK_EN
    logic               d_in, e_in, mismatch;
    logic [3:0]         err_cnt;
    int                 fault_mode = 0;
    int                 exp_err = 0;
    int                 pulse_cnt = 0;
`endif

    gate_pattern_seq #(.DWELL_W(DWELL_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dwell    (dwell),
        .a        (a),
        .b        (b),
        .c        (c),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
`ifdef GATE_PATTERN_SEQ_CHECK_EN
        ,
        .d_in     (d_in),
        .e_in     (e_in),
        .mismatch (mismatch),
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

`ifdef GATE_PATTERN_SEQ_CHECK_EN
    // Models the downstream gate: correct OR/NOR, or d_in stuck at 0.
    always_comb begin
        d_in = (fault_mode != 0) ? 1'b0 : (a | b | c);
        e_in = ~(a | b | c);
    end
`endif

    // Expected per-cycle tuple {valid, busy, done, a, b, c}
    logic [5:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: 8 patterns in order, each held max(dwell,1) cycles, then one done cycle.
    task automatic push_sweep(input int dw);
        int eff;
        eff = (dw == 0) ? 1 : dw;
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < eff; k++) begin
                exp_q.push_back({1'b1, 1'b1, 1'b0, 3'(p)});
            end
        end
        exp_q.push_back(6'b011_000);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
`ifdef GATE_PATTERN_SEQ_CHECK_EN
            if (mismatch) pulse_cnt++;
`endif
            if (busy || valid || done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'({valid, busy, done, a, b, c}), 32'd0);
                end else begin
                    check("sweep_out", 32'({valid, busy, done, a, b, c}), 32'(exp_q.pop_front()));
                end
`ifdef GATE_PATTERN_SEQ_CHECK_EN
                if (done) begin
                    check("err_cnt_at_done", 32'(err_cnt), 32'(exp_err));
                    check("mismatch_pulses", 32'(pulse_cnt), 32'(exp_err));
                end
`endif
            end else if ({a, b, c} != 3'b000) begin
                check("idle_pattern", 32'({a, b, c}), 32'd0);
            end
        end
    end

    task automatic issue_start(input int dw);
        @(negedge clk);
        dwell = DWELL_W'(dw);
        start = 1'b1;
        push_sweep(dw);
`ifdef GATE_PATTERN_SEQ_CHECK_EN
        pulse_cnt = 0;
        exp_err   = (fault_mode != 0) ? 7 : 0;
`endif
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input bit disturb);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 * 256 + 16 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else if (disturb) begin
                start = ($urandom_range(0, 3) == 0) || ({a, b, c} == 3'b010);
                dwell = DWELL_W'($urandom);
            end
        end
        start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_sweep(input int dw, input bit disturb);
        issue_start(dw);
        wait_done(disturb);
    endtask

    initial begin
        bit found;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'({valid, busy, done, a, b, c}), 32'd0);
`ifdef GATE_PATTERN_SEQ_CHECK_EN
        check("reset_checker", 32'({mismatch, err_cnt}), 32'd0);
`endif
        rst_n = 1'b1;

        run_sweep(1, 1'b0);
`ifdef GATE_PATTERN_SEQ_CHECK_EN
        fault_mode = 1;
`endif
        run_sweep(3, 1'b0);
`ifdef GATE_PATTERN_SEQ_CHECK_EN
        fault_mode = 0;
`endif
        run_sweep(0, 1'b0);
        run_sweep(2, 1'b1);
        run_sweep(1, 1'b1);

        // start held only across the DONE cycle must be ignored
        issue_start(1);
        wait_done(1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);

        for (int s = 0; s < 6; s++) begin
`ifdef GATE_PATTERN_SEQ_CHECK_EN
            fault_mode = int'($urandom_range(0, 1));
`endif
            run_sweep(int'($urandom_range(0, 5)), 1'(($urandom_range(0, 1))));
        end

        // Asynchronous reset while pattern 101 is driven aborts the sweep.
        issue_start(2);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (valid && ({a, b, c} == 3'b101)) found = 1'b1;
        end
        check("reached_101", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outs", 32'({valid, busy, done, a, b, c}), 32'd0);
`ifdef GATE_PATTERN_SEQ_CHECK_EN
        check("async_reset_checker", 32'({mismatch, err_cnt}), 32'd0);
`endif
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("held_reset_outs", 32'({valid, busy, done, a, b, c}), 32'd0);
        rst_n = 1'b1;
        run_sweep(1, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
